// File: rtl/execute_alu_if.sv
// Operand/result bundle between the operand stage and the execute ALU.
// The master side issues operands; the slave side (the ALU) returns results.
interface execute_alu_if #(
    parameter int W = 64
);
    logic         alu_en;
    logic [5:0]   alu_control;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic [4:0]   dest_in;
    logic         busy;
    logic [W-1:0] writeBack;
    logic         write_en;
    logic [4:0]   addressC;
    logic         illegal_op;

    modport master (
        output alu_en, alu_control, dataA, dataB, dest_in,
        input  busy, writeBack, write_en, addressC, illegal_op
    );

    modport slave (
        input  alu_en, alu_control, dataA, dataB, dest_in,
        output busy, writeBack, write_en, addressC, illegal_op
    );
endinterface

// File: rtl/execute_alu.sv
// Execute-stage ALU: single-cycle integer ops plus an optional restoring divider.
// Define ALU_MULDIV_EN to build MUL/DIV/DIVU/REM/REMU; otherwise those opcodes are illegal.
//
// state | meaning
// IDLE  | accepting operands; single-cycle ops and divide corner cases finish here
// DIV   | one restoring quotient bit per cycle, W cycles
// DONE  | sign fix-up, write strobe, busy released
module execute_alu #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input logic          clk,
    input logic          rst_n,
    execute_alu_if.slave alu
);
    localparam int W  = BUS_DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   wb_q, wb_d;
    logic [4:0]     addr_q, addr_d;
    logic           we_q, we_d;
    logic           ill_q, ill_d;

    logic [W-1:0]   a, b;
    logic [5:0]     shamt;
    logic [W-1:0]   simple_res;
    logic           legal_simple;

    assign a     = alu.dataA;
    assign b     = alu.dataB;
    assign shamt = alu.dataB[5:0];

    always_comb begin
        simple_res   = '0;
        legal_simple = 1'b1;
        case (alu.alu_control)
            6'd0:    simple_res = a + b;
            6'd1:    simple_res = a - b;
            6'd2:    simple_res = a & b;
            6'd3:    simple_res = a | b;
            6'd4:    simple_res = a ^ b;
            6'd5:    simple_res = a << shamt;
            6'd6:    simple_res = a >> shamt;
            6'd7:    simple_res = $signed(a) >>> shamt;
            6'd8:    simple_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            6'd9:    simple_res = {{(W-1){1'b0}}, a < b};
`ifdef ALU_MULDIV_EN
            6'd10:   simple_res = a * b;
`endif
            default: legal_simple = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, rem_op_q, rem_op_d;
    logic [4:0]    dest_q, dest_d;
    logic          busy_q, busy_d;
    logic          is_div, is_signed, is_rem, a_neg, b_neg;
    logic [W:0]    shifted, trial;

    assign is_div    = (alu.alu_control >= 6'd11) && (alu.alu_control <= 6'd14);
    assign is_signed = (alu.alu_control == 6'd11) || (alu.alu_control == 6'd13);
    assign is_rem    = (alu.alu_control == 6'd13) || (alu.alu_control == 6'd14);
    assign a_neg     = is_signed & a[W-1];
    assign b_neg     = is_signed & b[W-1];
    // The partial remainder never exceeds the divisor, so one extra bit detects the borrow.
    assign shifted   = {rem_q, quo_q[W-1]};
    assign trial     = shifted - {1'b0, dvs_q};
    assign alu.busy  = busy_q;
`else
    assign alu.busy  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wb_d    = wb_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        ill_d   = 1'b0;
`ifdef ALU_MULDIV_EN
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_op_d  = rem_op_q;
        dest_d    = dest_q;
        busy_d    = busy_q;
`endif
        case (state_q)
            IDLE: begin
                if (alu.alu_en) begin
                    if (legal_simple) begin
                        wb_d   = simple_res;
                        addr_d = alu.dest_in;
                        we_d   = (alu.dest_in != 5'd0);
                    end
`ifdef ALU_MULDIV_EN
                    else if (is_div) begin
                        if (b == '0) begin
                            wb_d   = is_rem ? a : '1;
                            addr_d = alu.dest_in;
                            we_d   = (alu.dest_in != 5'd0);
                        end else if (is_signed && (a == MIN_NEG) && (b == '1)) begin
                            wb_d   = is_rem ? '0 : a;
                            addr_d = alu.dest_in;
                            we_d   = (alu.dest_in != 5'd0);
                        end else begin
                            quo_d     = a_neg ? -a : a;
                            rem_d     = '0;
                            dvs_d     = b_neg ? -b : b;
                            cnt_d     = CW'(W - 1);
                            neg_quo_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            rem_op_d  = is_rem;
                            dest_d    = alu.dest_in;
                            busy_d    = 1'b1;
                            state_d   = DIV;
                        end
                    end
`endif
                    else begin
                        ill_d = 1'b1;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            DIV: begin
                rem_d = trial[W] ? shifted[W-1:0] : trial[W-1:0];
                quo_d = {quo_q[W-2:0], ~trial[W]};
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                if (rem_op_q) wb_d = neg_rem_q ? -rem_q : rem_q;
                else          wb_d = neg_quo_q ? -quo_q : quo_q;
                addr_d  = dest_q;
                we_d    = (dest_q != 5'd0);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wb_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_op_q  <= 1'b0;
            dest_q    <= '0;
            busy_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
`ifdef ALU_MULDIV_EN
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_op_q  <= rem_op_d;
            dest_q    <= dest_d;
            busy_q    <= busy_d;
`endif
        end
    end

    assign alu.writeBack  = wb_q;
    assign alu.addressC   = addr_q;
    assign alu.write_en   = we_q;
    assign alu.illegal_op = ill_q;
endmodule
